wb_gpio: RTL and testbench

Eight-bit general-purpose I/O controller with a Wishbone classic slave port. It owns the output, direction and synchronised-input registers whose values drive the GPIO monitor in simulation (IN_O, OUT_O, DIR_O), and it raises a maskable per-pin edge interrupt. It sits between the system Wishbone interconnect and the pads.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_sync.sv | 36 +++
 rtl/wb_gpio.sv | 110 +++++++++++
 tb/tb_wb_gpio.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the eight-bit Wishbone GPIO block: pin width and
// register word addresses.
package gpio_pkg;

  localparam int GPIO_WIDTH = 8;

  typedef logic [GPIO_WIDTH-1:0] gpio_t;

  localparam logic [2:0] GPIO_ADR_OUT     = 3'd0;
  localparam logic [2:0] GPIO_ADR_DIR     = 3'd1;
  localparam logic [2:0] GPIO_ADR_IN      = 3'd2;
  localparam logic [2:0] GPIO_ADR_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_ADR_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_ADR_STATUS  = 3'd5;

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser followed by a one-cycle history register, producing
// the synchronised pin value and per-pin rise/fall pulses.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  gpio_t pad_i,
  output gpio_t in_o,
  output gpio_t rise_o,
  output gpio_t fall_o
);

  gpio_t sync_q [SYNC_STAGES];
  gpio_t prev_q;

  // NOTE: the chain is reset even though it is an array; IN_O must read 0
  // until SYNC_STAGES edges after reset release, so no stage may start as X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_o   = sync_q[SYNC_STAGES-1];
  assign rise_o = in_o & ~prev_q;
  assign fall_o = ~in_o & prev_q;

endmodule

// File: rtl/wb_gpio.sv
// Eight-bit GPIO controller with a Wishbone classic slave port: output and
// direction registers, synchronised inputs and a maskable edge interrupt.
module wb_gpio
  import gpio_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter gpio_t OUT_RESET   = 8'h00
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [2:0]  ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic [7:0]  PAD_I,
  output logic [7:0]  IN_O,
  output logic [7:0]  OUT_O,
  output logic [7:0]  DIR_O,
  output logic        IRQ_O
);

  gpio_t in_w, rise_w, fall_w;

  logic  ack_q,     ack_d;
  gpio_t dat_q,     dat_d;
  gpio_t out_q,     dir_q;
  gpio_t rise_en_q, fall_en_q;
  gpio_t status_q,  status_d;
  gpio_t clr_w;
  logic  access_w, wr_w;

  // Upper byte selects and data bits carry nothing for an 8-bit register file.
  logic  unused_bits;
  assign unused_bits = &{1'b0, SEL_I[3:1], DAT_I[31:GPIO_WIDTH]};

  gpio_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (CLK_I),
    .rst_i (RST_I),
    .pad_i (PAD_I),
    .in_o  (in_w),
    .rise_o(rise_w),
    .fall_o(fall_w)
  );

  // A new transfer starts only while ACK_O is low, so a held strobe is
  // acknowledged every other cycle, one transfer per ACK.
  assign access_w = CYC_I & STB_I & ~ack_q;
  assign wr_w     = access_w & WE_I & SEL_I[0];
  assign ack_d    = access_w;

  assign clr_w    = (wr_w && ADR_I == GPIO_ADR_STATUS) ? DAT_I[GPIO_WIDTH-1:0] : '0;
  // Set terms are OR-ed after the clear so a new edge wins over W1C.
  assign status_d = (status_q & ~clr_w) | (rise_w & rise_en_q) | (fall_w & fall_en_q);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    dat_d = '0;
    unique case (ADR_I)
      GPIO_ADR_OUT:     dat_d = out_q;
      GPIO_ADR_DIR:     dat_d = dir_q;
      GPIO_ADR_IN:      dat_d = in_w;
      GPIO_ADR_RISE_EN: dat_d = rise_en_q;
      GPIO_ADR_FALL_EN: dat_d = fall_en_q;
      GPIO_ADR_STATUS:  dat_d = status_q;
      default:          dat_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      out_q     <= OUT_RESET;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      status_q <= status_d;
      if (access_w) dat_q <= dat_d;
      if (wr_w) begin
        unique case (ADR_I)
          GPIO_ADR_OUT:     out_q     <= DAT_I[GPIO_WIDTH-1:0];
          GPIO_ADR_DIR:     dir_q     <= DAT_I[GPIO_WIDTH-1:0];
          GPIO_ADR_RISE_EN: rise_en_q <= DAT_I[GPIO_WIDTH-1:0];
          GPIO_ADR_FALL_EN: fall_en_q <= DAT_I[GPIO_WIDTH-1:0];
          default:          ;
        endcase
      end
    end
  end

  assign DAT_O = {{(32-GPIO_WIDTH){1'b0}}, dat_q};
  assign ACK_O = ack_q;
  assign IN_O  = in_w;
  assign OUT_O = out_q;
  assign DIR_O = dir_q;
  assign IRQ_O = |status_q;

endmodule

// File: tb/tb_wb_gpio.sv
// Directed self-checking bench for wb_gpio with SYNC_STAGES=2, OUT_RESET=A5.
module tb_wb_gpio;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        CYC_I, STB_I, WE_I;
  logic [2:0]  ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [7:0]  PAD_I;
  logic [7:0]  IN_O, OUT_O, DIR_O;
  logic        IRQ_O;

  int vectors    = 0;
  int miscompares = 0;

  wb_gpio #(
    .SYNC_STAGES(2),
    .OUT_RESET  (8'hA5)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O),
    .PAD_I(PAD_I),
    .IN_O(IN_O), .OUT_O(OUT_O), .DIR_O(DIR_O),
    .IRQ_O(IRQ_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic bus_idle();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = '0; SEL_I = '0; DAT_I = '0;
  endtask

  task automatic wb_write(input string tag, input logic [2:0] adr,
                          input logic [7:0] data, input logic [3:0] sel);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    ADR_I = adr; SEL_I = sel; DAT_I = {24'h0, data};
    tick();
    check({tag, "_ack"}, ACK_O, 1'b1);
    bus_idle();
    tick();
    check({tag, "_ack_low"}, ACK_O, 1'b0);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] adr, input logic [7:0] exp);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0;
    ADR_I = adr; SEL_I = 4'b0001; DAT_I = '0;
    tick();
    check({tag, "_ack"}, ACK_O, 1'b1);
    check(tag, DAT_O, {24'h0, exp});
    bus_idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_I = 1'b1;
    PAD_I = 8'h00;
    bus_idle();
    tick(); tick(); tick();
    RST_I = 1'b0;

    // Reset state
    check("rst_out",  OUT_O, 8'hA5);
    check("rst_dir",  DIR_O, 8'h00);
    check("rst_ack",  ACK_O, 1'b0);
    check("rst_irq",  IRQ_O, 1'b0);
    check("rst_dato", DAT_O, 32'h0);
    check("rst_in",   IN_O,  8'h00);
    wb_read("rst_rd_dir",    3'd1, 8'h00);
    wb_read("rst_rd_riseen", 3'd3, 8'h00);
    wb_read("rst_rd_fallen", 3'd4, 8'h00);
    wb_read("rst_rd_status", 3'd5, 8'h00);
    wb_read("rst_rd_out",    3'd0, 8'hA5);

    // Write OUT: value visible on the ACK edge, ACK one cycle
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    ADR_I = 3'd0; SEL_I = 4'b0001; DAT_I = 32'h0000_003C;
    tick();
    check("wr_out_ack", ACK_O, 1'b1);
    check("wr_out_val", OUT_O, 8'h3C);
    bus_idle();
    tick();
    check("wr_out_ack_low", ACK_O, 1'b0);

    // SEL_I[0]=0 acknowledges without writing
    wb_write("wr_nosel", 3'd0, 8'h55, 4'b0000);
    check("nosel_out", OUT_O, 8'h3C);
    wb_read("rd_adr6", 3'd6, 8'h00);
    wb_write("wr_in", 3'd2, 8'hFF, 4'b0001);
    wb_read("rd_in", 3'd2, 8'h00);
    wb_write("wr_dir", 3'd1, 8'h0F, 4'b0001);
    check("dir_val", DIR_O, 8'h0F);
    wb_read("rd_dir", 3'd1, 8'h0F);

    // Held strobe: ACK on alternate cycles
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 3'd0; SEL_I = 4'b0001;
    tick(); check("held_ack1", ACK_O, 1'b1);
    tick(); check("held_ack2", ACK_O, 1'b0);
    tick(); check("held_ack3", ACK_O, 1'b1);
    bus_idle();
    tick();

    // Rising edge on pin 0
    wb_write("wr_riseen", 3'd3, 8'h01, 4'b0001);
    PAD_I = 8'h01;
    tick();                       // edge k
    check("rise_in_k", IN_O, 8'h00);
    tick();                       // edge k+1
    check("rise_in_k1", IN_O, 8'h01);
    check("rise_irq_k1", IRQ_O, 1'b0);
    tick();                       // edge k+2
    check("rise_irq_k2", IRQ_O, 1'b1);
    wb_read("rise_status", 3'd5, 8'h01);
    wb_write("clr0", 3'd5, 8'h01, 4'b0001);
    check("clr0_irq", IRQ_O, 1'b0);

    // Pin 7 rise is masked, then its fall is enabled
    PAD_I = 8'h81;
    tick(); tick(); tick();
    check("masked_rise_irq", IRQ_O, 1'b0);
    wb_write("wr_fallen", 3'd4, 8'h80, 4'b0001);
    PAD_I = 8'h01;
    tick(); tick();
    check("fall_irq_k1", IRQ_O, 1'b0);
    tick();
    check("fall_irq_k2", IRQ_O, 1'b1);
    wb_read("fall_status", 3'd5, 8'h80);
    wb_write("dis_fallen", 3'd4, 8'h00, 4'b0001);
    wb_read("status_kept", 3'd5, 8'h80);
    wb_write("clr7", 3'd5, 8'h80, 4'b0001);
    check("clr7_irq", IRQ_O, 1'b0);
    wb_read("clr7_status", 3'd5, 8'h00);

    // W1C collides with a new rise on pin 0: set wins
    PAD_I = 8'h00;
    tick(); tick(); tick();
    check("pre_coll_irq", IRQ_O, 1'b0);
    PAD_I = 8'h01;
    tick();                       // edge k
    tick();                       // edge k+1
    check("coll_irq_k1", IRQ_O, 1'b0);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    ADR_I = 3'd5; SEL_I = 4'b0001; DAT_I = 32'h0000_0001;
    tick();                       // edge k+2: rise and clear together
    check("coll_ack", ACK_O, 1'b1);
    check("coll_irq_k2", IRQ_O, 1'b1);
    bus_idle();
    tick();
    check("coll_irq_after", IRQ_O, 1'b1);
    wb_read("coll_status", 3'd5, 8'h01);

    // Reset aborts a write to DIR
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    ADR_I = 3'd1; SEL_I = 4'b0001; DAT_I = 32'h0000_00FF;
    RST_I = 1'b1;
    tick();
    check("abort_ack", ACK_O, 1'b0);
    check("abort_dir", DIR_O, 8'h00);
    check("abort_out", OUT_O, 8'hA5);
    check("abort_irq", IRQ_O, 1'b0);
    RST_I = 1'b0;
    bus_idle();
    tick();
    wb_write("post_rst_dir", 3'd1, 8'hFF, 4'b0001);
    check("post_rst_dir_val", DIR_O, 8'hFF);
    tick(); tick();
    check("post_rst_irq", IRQ_O, 1'b0);
    check("post_rst_in", IN_O, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
